// File: rtl/encoder_seq_pkg.sv
// Shared types and widths for the encoder_seq set-bit sequencer.
package encoder_seq_pkg;

    localparam int VEC_W  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/encoder_seq_prio_find.sv
// Combinational priority finder: index of the lowest or highest set bit plus a single-bit-set flag.
module prio_find
    import encoder_seq_pkg::*;
(
    input  logic [VEC_W-1:0]  i_vec,
    input  logic              i_lsb_first,
    output logic [CODE_W-1:0] o_idx,
    output logic              o_one
);

    // Scan so that the preferred end is visited last and therefore wins.
    always_comb begin
        o_idx = '0;
        if (i_lsb_first) begin
            for (int i = VEC_W - 1; i >= 0; i--) begin
                if (i_vec[i]) begin
                    o_idx = CODE_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < VEC_W; i++) begin
                if (i_vec[i]) begin
                    o_idx = CODE_W'(i);
                end
            end
        end
    end

    always_comb begin
        o_one = (i_vec != '0) && ((i_vec & (i_vec - VEC_W'(1))) == '0);
    end

endmodule

// File: rtl/encoder_seq.sv
// Accepts an 8-bit request vector and emits the index of each set bit, one per output handshake.
// Optional macro ENC_ZERO_ERR_EN adds an err pulse for accepted all-zero vectors.
module encoder_seq
    import encoder_seq_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VEC_W-1:0]  in_vec,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef ENC_ZERO_ERR_EN
    ,
    output logic              err
`endif
);

    state_t             r_state;
    state_t             w_nextState;
    logic [VEC_W-1:0]   r_pending;
    logic [CODE_W-1:0]  w_idx;
    logic               w_one;
    logic               w_inHs;
    logic               w_outHs;

    prio_find u_prio_find (
        .i_vec       (r_pending),
        .i_lsb_first (LSB_FIRST),
        .o_idx       (w_idx),
        .o_one       (w_one)
    );

    assign w_inHs  = in_valid  && (r_state == IDLE);
    assign w_outHs = out_ready && (r_state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_inHs && (in_vec != '0)) w_nextState = BUSY;
            BUSY: if (w_outHs && w_one)         w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == BUSY);
        out_code  = (r_state == BUSY) ? w_idx : '0;
        out_last  = (r_state == BUSY) && w_one;
    end

    // Zero vectors never load, so IDLE always sees an empty pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (w_inHs && (in_vec != '0)) begin
            r_pending <= in_vec;
        end else if (w_outHs) begin
            r_pending <= r_pending & ~(VEC_W'(1) << w_idx);
        end
    end

`ifdef ENC_ZERO_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_inHs && (in_vec == '0);
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_encoder_seq.sv
// Randomized and directed bench for encoder_seq, checking both emit orders against a queue-based model.
module tb_encoder_seq;

    logic       clk;
    logic       rstN;
    logic [7:0] inVec;
    logic       inValid;
    logic       outReady;

    logic       inReadyL, outValidL, outLastL;
    logic [2:0] outCodeL;
    logic       inReadyM, outValidM, outLastM;
    logic [2:0] outCodeM;
`ifdef ENC_ZERO_ERR_EN
    logic       errL, errM;
`endif

    int compareCount;
    int mismatchCount;

    // Reference model: the codes still to emit, listed in emit order for each direction.
    int   qL[$];
    int   qM[$];
    bit   mBusy;
    bit   errExp;

    encoder_seq #(.LSB_FIRST(1'b1)) dutL (
        .clk       (clk),
        .rst_n     (rstN),
        .in_vec    (inVec),
        .in_valid  (inValid),
        .in_ready  (inReadyL),
        .out_code  (outCodeL),
        .out_valid (outValidL),
        .out_ready (outReady),
        .out_last  (outLastL)
`ifdef ENC_ZERO_ERR_EN
        ,
        .err       (errL)
`endif
    );

    encoder_seq #(.LSB_FIRST(1'b0)) dutM (
        .clk       (clk),
        .rst_n     (rstN),
        .in_vec    (inVec),
        .in_valid  (inValid),
        .in_ready  (inReadyM),
        .out_code  (outCodeM),
        .out_valid (outValidM),
        .out_ready (outReady),
        .out_last  (outLastM)
`ifdef ENC_ZERO_ERR_EN
        ,
        .err       (errM)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic checkAll();
        logic [7:0] expCodeL;
        logic [7:0] expCodeM;
        expCodeL = mBusy ? 8'(qL[0]) : 8'h00;
        expCodeM = mBusy ? 8'(qM[0]) : 8'h00;
        checkOutput("in_ready_lsb",  {7'b0, inReadyL},  {7'b0, !mBusy});
        checkOutput("out_valid_lsb", {7'b0, outValidL}, {7'b0, mBusy});
        checkOutput("out_code_lsb",  {5'b0, outCodeL},  expCodeL);
        checkOutput("out_last_lsb",  {7'b0, outLastL},  {7'b0, mBusy && (qL.size() == 1)});
        checkOutput("in_ready_msb",  {7'b0, inReadyM},  {7'b0, !mBusy});
        checkOutput("out_valid_msb", {7'b0, outValidM}, {7'b0, mBusy});
        checkOutput("out_code_msb",  {5'b0, outCodeM},  expCodeM);
        checkOutput("out_last_msb",  {7'b0, outLastM},  {7'b0, mBusy && (qM.size() == 1)});
`ifdef ENC_ZERO_ERR_EN
        checkOutput("err_lsb", {7'b0, errL}, {7'b0, errExp});
        checkOutput("err_msb", {7'b0, errM}, {7'b0, errExp});
`endif
    endtask

    // Advance the model by one clock edge using the inputs presented on that edge.
    task automatic modelStep();
        bit accept;
        accept = !mBusy && inValid;
        errExp = accept && (inVec == 8'h00);
        if (mBusy && outReady) begin
            void'(qL.pop_front());
            void'(qM.pop_front());
            if (qL.size() == 0) mBusy = 1'b0;
        end else if (accept && (inVec != 8'h00)) begin
            for (int i = 0; i < 8; i++) if (inVec[i]) qL.push_back(i);
            for (int i = 7; i >= 0; i--) if (inVec[i]) qM.push_back(i);
            mBusy = 1'b1;
        end
    endtask

    task automatic modelReset();
        qL.delete();
        qM.delete();
        mBusy  = 1'b0;
        errExp = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] vec, input logic valid, input logic ready);
        @(negedge clk);
        checkAll();
        inVec    = vec;
        inValid  = valid;
        outReady = ready;
        @(posedge clk);
        modelStep();
    endtask

    // Reset lands between clock edges so its asynchronous effect is visible straight away.
    task automatic pulseReset();
        @(negedge clk);
        #2;
        rstN = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        modelReset();
        rstN     = 1'b0;
        inVec    = 8'h00;
        inValid  = 1'b0;
        outReady = 1'b0;
        #12;
        checkAll();
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] two-bit vector, both orders");
        applyStimulus(8'h24, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0, 1'b1);

        $display("[TB] full vector with stalling consumer");
        applyStimulus(8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) applyStimulus(8'h00, 1'b0, (i % 2) == 0);

        $display("[TB] zero vector");
        applyStimulus(8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0, 1'b1);

        $display("[TB] reset mid-vector");
        applyStimulus(8'h81, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        pulseReset();
        for (int i = 0; i < 4; i++) applyStimulus(8'h00, 1'b0, 1'b1);

        $display("[TB] input held valid while busy");
        applyStimulus(8'h24, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            applyStimulus(8'($urandom), 1'b1, $urandom_range(0, 1) == 1);
        for (int i = 0; i < 10; i++) applyStimulus(8'h00, 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic [7:0] vec;
            vec = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 99) == 0) pulseReset();
            applyStimulus(vec, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        checkAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/encoder_seq.md
ENCODER_SEQ -- requirements
Module: encoder_seq

Interface
REQ-001 Parameter: LSB_FIRST, default 1, 1 = lowest set bit index emitted first; 0 = highest set bit index emitted first.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_vec  input  8  request vector; bit i set = code i to be emitted.
REQ-005 Port: in_valid  input  1  in_vec valid this cycle.
REQ-006 Port: in_ready  output  1  block can accept a vector.
REQ-007 Port: out_code  output  3  encoded index of current set bit.
REQ-008 Port: out_valid  output  1  out_code valid.
REQ-009 Port: out_ready  input  1  consumer accepts out_code.
REQ-010 Port: out_last  output  1  current out_code is the final code of the accepted vector.
REQ-011 Port: err  output  1  one-cycle pulse on all-zero vector accepted (present only with ENC_ZERO_ERR_EN).

Function
REQ-012 Two states SHALL exist: IDLE and BUSY; the 8-bit register pending holds the bits still to emit.
REQ-013 in_ready SHALL be 1 exactly when state = IDLE; out_valid SHALL be 1 exactly when state = BUSY.
REQ-014 Input handshake SHALL occur on a cycle with in_valid=1 and in_ready=1.
REQ-015 On a handshake with in_vec != 0: pending <= in_vec, state <= BUSY; out_valid SHALL rise on the next cycle (latency 1).
REQ-016 On a handshake with in_vec == 0: state stays IDLE, nothing emitted, vector dropped.
REQ-017 In BUSY, out_code SHALL be the index of the lowest set bit of pending (LSB_FIRST=1) or the highest set bit (LSB_FIRST=0), derived from registered state only.
REQ-018 out_last SHALL be 1 in BUSY when pending has exactly one bit set; 0 otherwise.
REQ-019 Output handshake (out_valid=1, out_ready=1) SHALL clear the bit of pending indexed by out_code; if out_last=1, state <= IDLE.
REQ-020 With out_ready=0, out_code, out_last and pending SHALL hold stable; no limit on stall length.
REQ-021 A vector with k set bits SHALL produce exactly k output handshakes, each index once, in strict priority order; minimum k cycles.
REQ-022 in_valid/in_vec changes during BUSY SHALL have no effect; no new vector is accepted until the cycle after the last output handshake (one idle cycle between vectors).
REQ-023 in_vec = 8'hFF SHALL emit all eight codes 0..7 (or 7..0) with out_last only on the eighth.

Reset
REQ-024 While rst_n=0: state=IDLE, pending=0, in_ready=1, out_valid=0, out_code=0, out_last=0, err=0.
REQ-025 Assertion of rst_n mid-BUSY SHALL discard pending immediately (asynchronous); no partial output after release.

Configuration
REQ-026 Macro ENC_ZERO_ERR_EN defined: err port exists; err=1 for exactly the cycle following an input handshake with in_vec == 0, else 0.
REQ-027 Macro ENC_ZERO_ERR_EN undefined: err port absent; zero vectors dropped silently per REQ-016.

Structure
REQ-028 Shared package SHALL hold: state enum (IDLE, BUSY), constants VEC_W=8 and CODE_W=3.
REQ-029 The priority-find logic SHALL be a sub-module prio_find (8-bit vector + direction in, 3-bit index + onehot-count-is-1 flag out), purely combinational.

Verification
REQ-030 in_vec=8'b0010_0100, LSB_FIRST=1, out_ready=1 -> codes 2 then 5; out_last on 5; in_ready high the cycle after.
REQ-031 Same vector, LSB_FIRST=0 -> codes 5 then 2; out_last on 2.
REQ-032 in_vec=8'hFF, out_ready toggled 1/0 each cycle -> codes 0..7 each held through stall cycles, 8 handshakes total, out_last only on 7.
REQ-033 in_vec=8'h00 accepted -> no out_valid; err pulses one cycle after (macro on); no err port (macro off).
REQ-034 in_vec=8'h81 accepted, rst_n pulsed low after first code -> outputs per REQ-024, no code 7 emitted after release.
REQ-035 in_valid held high with changing in_vec during BUSY -> ignored; next vector accepted only once in_ready returns high.
